scarv_cop_mul_sched: RTL

Shared iterative packed-multiplier scheduler for the SCARV coprocessor. It arbitrates one bit-serial shift-add multiplier between two requesters: requester 0 is the packed-arithmetic ALU and requester 1 is the multi-precision unit. It sequences the multiplier one operand bit per cycle across all packed lanes, in both integer and carry-less modes. The selected low or high half of each lane product is returned to the requester that issued the operation.

---
 rtl/scarv_cop_mul_sched_pkg.sv | 124 ++++++++++++
 rtl/scarv_cop_mul_sched_arb.sv | 34 +++
 rtl/scarv_cop_mul_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_mul_sched_pkg.sv
// Shared types, pack-width codes and lane helpers for the SCARV multiplier scheduler.
// Lane helpers work on any power-of-two lane width w in 2..32 with 2w-bit accumulator slices.
package scarv_cop_mul_sched_pkg;

    localparam logic [2:0] PW_32 = 3'b000;
    localparam logic [2:0] PW_16 = 3'b001;
    localparam logic [2:0] PW_8  = 3'b010;
    localparam logic [2:0] PW_4  = 3'b011;
    localparam logic [2:0] PW_2  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Reserved codes fall back to full 32-bit lanes.
    function automatic logic [5:0] lane_width(input logic [2:0] pw);
        logic [5:0] w;
        case (pw)
            PW_32:   w = 6'd32;
            PW_16:   w = 6'd16;
            PW_8:    w = 6'd8;
            PW_4:    w = 6'd4;
            PW_2:    w = 6'd2;
            default: w = 6'd32;
        endcase
        return w;
    endfunction

    function automatic logic [5:0] slice_mask(input logic [5:0] w);
        return 6'(({1'b0, w} << 1) - 7'd1);
    endfunction

    // Place each w-bit lane of v zero-extended into its own 2w-bit slice.
    function automatic logic [63:0] spread_lanes(input logic [31:0] v, input logic [5:0] w);
        logic [63:0] r;
        logic [5:0]  m2;
        logic [5:0]  pos;
        logic [5:0]  off;
        logic [5:0]  base;
        r  = 64'd0;
        m2 = slice_mask(w);
        for (int p = 0; p < 64; p++) begin
            pos  = 6'(p);
            off  = pos & m2;
            base = (pos & ~m2) >> 1;
            if (off < w) begin
                r[p] = v[5'(base + off)];
            end else begin
                r[p] = 1'b0;
            end
        end
        return r;
    endfunction

    // Replicate bit k of each lane of v across that lane's 2w-bit slice.
    function automatic logic [63:0] lane_bits(input logic [31:0] v, input logic [5:0] w,
                                              input logic [4:0] k);
        logic [63:0] r;
        logic [5:0]  m2;
        logic [5:0]  base;
        r  = 64'd0;
        m2 = slice_mask(w);
        for (int p = 0; p < 64; p++) begin
            base = (6'(p) & ~m2) >> 1;
            r[p] = v[5'(base + {1'b0, k})];
        end
        return r;
    endfunction

    // Ripple add with the carry killed at every 2w slice boundary.
    function automatic logic [63:0] lane_add(input logic [63:0] x, input logic [63:0] y,
                                             input logic [5:0] w);
        logic [63:0] r;
        logic [5:0]  m2;
        logic        carry;
        logic        c;
        r     = 64'd0;
        carry = 1'b0;
        m2    = slice_mask(w);
        for (int p = 0; p < 64; p++) begin
            c     = ((6'(p) & m2) == 6'd0) ? 1'b0 : carry;
            r[p]  = x[p] ^ y[p] ^ c;
            carry = (x[p] & y[p]) | (c & (x[p] ^ y[p]));
        end
        return r;
    endfunction

    // True when any lane still has a set multiplier bit above position k.
    function automatic logic bits_pending(input logic [31:0] v, input logic [5:0] w,
                                          input logic [4:0] k);
        logic       pend;
        logic [5:0] m1;
        pend = 1'b0;
        m1   = w - 6'd1;
        for (int q = 0; q < 32; q++) begin
            if ((6'(q) & m1) > {1'b0, k}) begin
                pend = pend | v[q];
            end else begin
                pend = pend;
            end
        end
        return pend;
    endfunction

    // Gather the low or high w bits of every 2w slice, lane 0 in the LSBs.
    function automatic logic [31:0] select_half(input logic [63:0] acc, input logic [5:0] w,
                                                input logic high);
        logic [31:0] r;
        logic [5:0]  m1;
        logic [5:0]  pos;
        logic [5:0]  src;
        r  = 32'd0;
        m1 = w - 6'd1;
        for (int q = 0; q < 32; q++) begin
            pos  = 6'(q);
            src  = ((pos & ~m1) << 1) + (pos & m1) + (high ? w : 6'd0);
            r[q] = acc[src];
        end
        return r;
    endfunction

endpackage

// File: rtl/scarv_cop_mul_sched_arb.sv
// Two-way round-robin arbiter for the shared multiplier; the pointer moves only on accept.
module scarv_cop_mul_rr_arb
    import scarv_cop_mul_sched_pkg::*;
(
    input  logic       g_clk,
    input  logic       g_reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr_r;

    // A lone requester always wins; on contention the pointer holder wins.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Priority passes to the requester that was not just served.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            ptr_r <= 1'b0;
        end else if (accept) begin
            ptr_r <= ~grant[1];
        end
    end

endmodule

// File: rtl/scarv_cop_mul_sched.sv
// Shared bit-serial packed multiplier scheduler for the SCARV coprocessor (ALU = req0, MP = req1).
// Define SCARV_COP_MUL_EARLY_EXIT_EN to finish once no multiplier bits remain (not constant-time).
module scarv_cop_mul_sched
    import scarv_cop_mul_sched_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [5:0]  req_pw,
    input  logic [1:0]  req_high,
    input  logic [1:0]  req_ncarry,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_result
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [1:0]  grant_s;
    logic        accept_s;
    logic [1:0]  req_ready_s;

    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [2:0]  sel_pw_s;
    logic        sel_high_s;
    logic        sel_ncarry_s;

    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [5:0]  w_r;
    logic        high_r;
    logic        ncarry_r;
    logic        owner_r;
    logic [63:0] acc_r;
    logic [4:0]  cnt_r;
    logic [1:0]  rsp_valid_r;
    logic [31:0] rsp_result_r;

    logic [63:0] pp_s;
    logic [63:0] acc_nxt_s;
    logic [31:0] result_nxt_s;
    logic        last_s;

    scarv_cop_mul_rr_arb u_arb (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .valid   (req_valid),
        .accept  (accept_s),
        .grant   (grant_s)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s      = 32'd0;
        sel_b_s      = 32'd0;
        sel_pw_s     = 3'b000;
        sel_high_s   = 1'b0;
        sel_ncarry_s = 1'b0;
        if (grant_s[1]) begin
            sel_a_s      = req_a[63:32];
            sel_b_s      = req_b[63:32];
            sel_pw_s     = req_pw[5:3];
            sel_high_s   = req_high[1];
            sel_ncarry_s = req_ncarry[1];
        end else begin
            sel_a_s      = req_a[31:0];
            sel_b_s      = req_b[31:0];
            sel_pw_s     = req_pw[2:0];
            sel_high_s   = req_high[0];
            sel_ncarry_s = req_ncarry[0];
        end
    end

    // One shift-add (or shift-xor) step across all lanes.
    always_comb begin
        pp_s = (spread_lanes(a_r, w_r) << cnt_r) & lane_bits(b_r, w_r, cnt_r);
        if (ncarry_r) begin
            acc_nxt_s = acc_r ^ pp_s;
        end else begin
            acc_nxt_s = lane_add(acc_r, pp_s, w_r);
        end
        result_nxt_s = select_half(acc_nxt_s, w_r, high_r);
    end

    // Final-iteration detection.
    always_comb begin
        last_s = 1'b0;
`ifdef SCARV_COP_MUL_EARLY_EXIT_EN
        if ((cnt_r == 5'(w_r - 6'd1)) || !bits_pending(b_r, w_r, cnt_r)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
`else
        if (cnt_r == 5'(w_r - 6'd1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
`endif
    end

    // Next state and the combinational ready.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        req_ready_s = 2'b00;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = grant_s;
                if (grant_s != 2'b00) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, operand capture, accumulator and registered response.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_r      <= ST_IDLE;
            a_r          <= 32'd0;
            b_r          <= 32'd0;
            w_r          <= 6'd32;
            high_r       <= 1'b0;
            ncarry_r     <= 1'b0;
            owner_r      <= 1'b0;
            acc_r        <= 64'd0;
            cnt_r        <= 5'd0;
            rsp_valid_r  <= 2'b00;
            rsp_result_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            rsp_valid_r <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r      <= sel_a_s;
                        b_r      <= sel_b_s;
                        w_r      <= lane_width(sel_pw_s);
                        high_r   <= sel_high_s;
                        ncarry_r <= sel_ncarry_s;
                        owner_r  <= grant_s[1];
                        acc_r    <= 64'd0;
                        cnt_r    <= 5'd0;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (last_s) begin
                        rsp_valid_r  <= owner_r ? 2'b10 : 2'b01;
                        rsp_result_r <= result_nxt_s;
                    end
                end
                ST_DONE: cnt_r <= 5'd0;
                default: cnt_r <= 5'd0;
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;

endmodule
